// File: rtl/ram4k_arbiter.sv
// -----------------------------------------------------------------------------
// ram4k_arbiter
//
// Purpose:
//   Shares one single-port RAM4K (4096 x 16, combinational read, write on the
//   rising clock edge) between two requesters, A and B. At most one requester
//   is granted per cycle. When both request at once, a round-robin pointer
//   picks the winner. A one-cycle clear_start pulse starts a hardware zero-fill
//   of all 4096 words. The fill takes exactly 4096 cycles, and no requester is
//   granted while it runs.
//
// Ports:
//   CLK          in   1   system clock, rising-edge active
//   reset        in   1   asynchronous, active-high reset
//   a_req        in   1   requester A request, held until granted
//   a_we         in   1   requester A write (1) / read (0)
//   a_addr       in  12   requester A word address
//   a_wdata      in  16   requester A write data
//   a_gnt        out  1   requester A accepted this cycle (combinational)
//   a_rvalid     out  1   requester A read data valid (one cycle after grant)
//   a_rdata      out 16   requester A read data (held while a_rvalid=0)
//   b_*          --  --   same set of ports for requester B
//   clear_start  in   1   one-cycle pulse that requests a zero-fill
//   clear_busy   out  1   zero-fill in progress
//   mem_in       out 16   RAM4K write data
//   mem_load     out  1   RAM4K write enable
//   mem_address  out 12   RAM4K address
//   mem_out      in  16   RAM4K read data for mem_address
// -----------------------------------------------------------------------------
module ram4k_arbiter (
  input  logic        CLK,
  input  logic        reset,

  input  logic        a_req,
  input  logic        a_we,
  input  logic [11:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,

  input  logic        b_req,
  input  logic        b_we,
  input  logic [11:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,

  input  logic        clear_start,
  output logic        clear_busy,

  output logic [15:0] mem_in,
  output logic        mem_load,
  output logic [11:0] mem_address,
  input  logic [15:0] mem_out
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [0:0] ST_SERVE = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [11:0] LAST_WORD = 12'hFFF;

  // Round-robin pointer values: the requester that wins a tie.
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [0:0]  r_state;
  logic [11:0] r_count;
  logic        r_ptr;
  logic        r_a_rvalid;
  logic        r_b_rvalid;
  logic [15:0] r_a_rdata;
  logic [15:0] r_b_rdata;

  // ---------------------------------------------------------------------------
  // Arbitration (combinational)
  // ---------------------------------------------------------------------------
  logic w_serve;       // SERVE state, not in reset, and no clear requested
  logic w_in_clear;    // zero-fill running and not in reset
  logic w_a_gnt;
  logic w_b_gnt;
  logic w_any_gnt;
  logic w_last_word;

  // A clear_start pulse takes priority over both requesters for its cycle.
  // Reset also blocks grants directly, so that none can appear while reset is
  // held, whatever the request inputs do.
  assign w_serve    = (r_state == ST_SERVE) && !reset && !clear_start;
  assign w_in_clear = (r_state == ST_CLEAR) && !reset;

  // A single requester always wins. When both request, the pointer decides.
  assign w_a_gnt   = w_serve && a_req && (!b_req || (r_ptr == PTR_A));
  assign w_b_gnt   = w_serve && b_req && (!a_req || (r_ptr == PTR_B));
  assign w_any_gnt = w_a_gnt || w_b_gnt;

  assign w_last_word = (r_count == LAST_WORD);

  assign a_gnt      = w_a_gnt;
  assign b_gnt      = w_b_gnt;
  assign clear_busy = (r_state == ST_CLEAR);

  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

  // ---------------------------------------------------------------------------
  // RAM port mux
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first. If any path left
  // one of them unassigned, synthesis would infer a latch.
  always_comb begin
    mem_load    = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    if (w_in_clear) begin
      mem_load    = 1'b1;
      mem_address = r_count;
      mem_in      = '0;
    end else if (w_a_gnt) begin
      mem_load    = a_we;
      mem_address = a_addr;
      mem_in      = a_wdata;
    end else if (w_b_gnt) begin
      mem_load    = b_we;
      mem_address = b_addr;
      mem_in      = b_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Control state: FSM, clear counter, round-robin pointer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples values from before the edge, so the order of the statements
  // does not matter.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= ST_SERVE;
      r_count <= '0;
      r_ptr   <= PTR_A;
    end else begin
      case (r_state)
        ST_SERVE: begin
          if (clear_start) begin
            r_state <= ST_CLEAR;
            r_count <= '0;
          end else if (w_any_gnt) begin
            // The winner goes to the back of the queue.
            r_ptr <= w_a_gnt ? PTR_B : PTR_A;
          end
        end
        ST_CLEAR: begin
          // clear_start has no effect here. The fill always runs to the last
          // word and then wraps the counter back to zero.
          r_count <= r_count + 12'd1;
          if (w_last_word) begin
            r_state <= ST_SERVE;
          end
        end
        default: begin
          r_state <= ST_SERVE;
          r_count <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path (latency 1)
  // ---------------------------------------------------------------------------
  // rvalid is high only in the cycle after a granted read. rdata captures
  // mem_out only on a granted read, so it holds its value between reads.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= w_a_gnt && !a_we;
      r_b_rvalid <= w_b_gnt && !b_we;
      if (w_a_gnt && !a_we) begin
        r_a_rdata <= mem_out;
      end
      if (w_b_gnt && !b_we) begin
        r_b_rdata <= mem_out;
      end
    end
  end

endmodule

// File: tb/tb_ram4k_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram4k_arbiter
//
// Directed bench for ram4k_arbiter. It holds a behavioural RAM4K: combinational
// read, write on the rising edge. Every word starts at 16'hC000 | address, so
// words that survive a fill can be told apart from zeroed ones. Inputs change
// on the falling edge. Outputs are sampled 1 time unit later, well away from
// the rising edge.
// -----------------------------------------------------------------------------
module tb_ram4k_arbiter;

  logic        CLK = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we, clear_start;
  logic [11:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, clear_busy, mem_load;
  logic [15:0] a_rdata, b_rdata, mem_in, mem_out;
  logic [11:0] mem_address;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [4096];

  ram4k_arbiter dut (
    .CLK         (CLK),
    .reset       (reset),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_gnt       (a_gnt),
    .a_rvalid    (a_rvalid),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_gnt       (b_gnt),
    .b_rvalid    (b_rvalid),
    .b_rdata     (b_rdata),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .mem_in      (mem_in),
    .mem_load    (mem_load),
    .mem_address (mem_address),
    .mem_out     (mem_out)
  );

  always #5 CLK = ~CLK;

  // RAM4K model
  assign mem_out = mem[mem_address];
  always @(posedge CLK) begin
    if (mem_load) mem[mem_address] <= mem_in;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Moves to the next falling edge. The caller then drives inputs and samples.
  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    clear_start = 0;
  endtask

  // Follows a full fill cycle by cycle, from the first CLEAR cycle to the last.
  // At cycle 2000, clear_start is pulsed again to show that it is ignored.
  task automatic watch_full_clear(input string tag);
    for (int k = 0; k < 4096; k++) begin
      next_cycle();
      clear_start = (k == 2000);
      settle();
      check({tag, " busy"}, clear_busy, 1);
      check({tag, " load"}, mem_load, 1);
      check({tag, " addr"}, mem_address, k);
      check({tag, " din"},  mem_in, 0);
      check({tag, " gnts"}, {a_gnt, b_gnt}, 2'b00);
    end
    clear_start = 0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'hC000 | 16'(i);
    idle_inputs();
    reset = 1;

    // ---- reset state; requests must not leak through while reset is held
    next_cycle();
    a_req = 1; b_req = 1; a_addr = 12'h123; a_we = 1; a_wdata = 16'hBEEF;
    settle();
    check("rst gnts",   {a_gnt, b_gnt}, 2'b00);
    check("rst load",   mem_load, 0);
    check("rst addr",   mem_address, 0);
    check("rst din",    mem_in, 0);
    check("rst busy",   clear_busy, 0);
    check("rst rvalid", {a_rvalid, b_rvalid}, 2'b00);
    check("rst rdata",  {a_rdata, b_rdata}, 32'h0);
    next_cycle();
    idle_inputs();
    reset = 0;
    settle();
    check("post-rst idle addr", mem_address, 0);

    // ---- A writes 0x1234 to 0x005, then reads it back
    next_cycle();
    a_req = 1; a_we = 1; a_addr = 12'h005; a_wdata = 16'h1234;
    settle();
    check("wr a_gnt", a_gnt, 1);
    check("wr b_gnt", b_gnt, 0);
    check("wr load",  mem_load, 1);
    check("wr addr",  mem_address, 12'h005);
    check("wr din",   mem_in, 16'h1234);
    next_cycle();
    a_we = 0; a_wdata = 16'h0;
    settle();
    check("rd a_gnt",    a_gnt, 1);
    check("rd load",     mem_load, 0);
    check("rd addr",     mem_address, 12'h005);
    check("wr no rvalid", a_rvalid, 0);
    next_cycle();
    a_req = 0;
    settle();
    check("rd a_rvalid", a_rvalid, 1);
    check("rd a_rdata",  a_rdata, 16'h1234);
    check("rd b_rvalid", b_rvalid, 0);
    check("idle gnt",    a_gnt, 0);
    check("idle bus",    {mem_load, mem_address, mem_in}, 29'h0);
    next_cycle();
    settle();
    check("rvalid 1 cyc", a_rvalid, 0);
    check("rdata hold",   a_rdata, 16'h1234);

    // ---- both request out of reset: A, B, A, B
    reset = 1;
    next_cycle();
    reset = 0;
    a_req = 1; b_req = 1; a_addr = 12'h005; b_addr = 12'h006;
    settle();
    check("rr c1 gnt", {a_gnt, b_gnt}, 2'b10);
    check("rr c1 addr", mem_address, 12'h005);
    next_cycle(); settle();
    check("rr c2 gnt", {a_gnt, b_gnt}, 2'b01);
    check("rr c2 addr", mem_address, 12'h006);
    check("rr a_rdata", {a_rvalid, a_rdata}, {1'b1, 16'h1234});
    next_cycle(); settle();
    check("rr c3 gnt", {a_gnt, b_gnt}, 2'b10);
    check("rr b_rdata", {b_rvalid, b_rdata}, {1'b1, 16'hC006});
    next_cycle(); settle();
    check("rr c4 gnt", {a_gnt, b_gnt}, 2'b01);
    next_cycle();
    idle_inputs();
    settle();
    check("rr stop", {a_gnt, b_gnt}, 2'b00);

    // ---- reset at counter=100 aborts the fill; no resumption afterwards
    next_cycle();
    clear_start = 1;
    settle();
    check("ab start busy", clear_busy, 0);
    for (int k = 0; k <= 100; k++) begin
      next_cycle();
      clear_start = 0;
      settle();
      check("ab addr", mem_address, k);
    end
    reset = 1;
    settle();
    check("ab busy",  clear_busy, 0);
    check("ab load",  mem_load, 0);
    check("ab addr0", mem_address, 0);
    next_cycle();
    reset = 0;
    next_cycle(); settle();
    check("ab no resume", {clear_busy, mem_load}, 2'b00);
    check("ab w0",    mem[0], 16'h0000);
    check("ab w99",   mem[99], 16'h0000);
    check("ab w100",  mem[100], 16'hC064);
    check("ab w4095", mem[4095], 16'hCFFF);

    // ---- fill 0..3 with FFFF, then clear with a_req held from clear_start
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      a_req = 1; a_we = 1; a_addr = 12'(i); a_wdata = 16'hFFFF;
      settle();
      check("fill gnt", a_gnt, 1);
    end
    next_cycle();
    a_req = 1; a_we = 0; a_addr = 12'h003; a_wdata = 16'h0;
    clear_start = 1;
    settle();
    check("cs a_gnt suppressed", a_gnt, 0);
    check("cs pre-clear w3", mem[3], 16'hFFFF);
    watch_full_clear("clrA");
    next_cycle(); settle();
    check("clrA done busy", clear_busy, 0);
    check("clrA first a_gnt", a_gnt, 1);
    check("clrA rd addr", mem_address, 12'h003);
    next_cycle();
    a_req = 0;
    settle();
    check("clrA rd result", {a_rvalid, a_rdata}, {1'b1, 16'h0000});
    check("clrA w4095", mem[4095], 16'h0000);

    // ---- B requests throughout a clear; granted first once it ends
    next_cycle();
    clear_start = 1;
    settle();
    next_cycle();
    clear_start = 0;
    b_req = 1; b_we = 0; b_addr = 12'h00A;
    settle();
    check("clrB busy", clear_busy, 1);
    check("clrB b_gnt", b_gnt, 0);
    for (int k = 1; k < 4096; k++) begin
      next_cycle(); settle();
      if (b_gnt !== 1'b0 || clear_busy !== 1'b1) begin
        check("clrB hold", {clear_busy, b_gnt}, 2'b10);
      end
    end
    next_cycle(); settle();
    check("clrB busy fell", clear_busy, 0);
    check("clrB first b_gnt", b_gnt, 1);
    next_cycle();
    b_req = 0;
    settle();
    check("clrB rd", {b_rvalid, b_rdata}, {1'b1, 16'h0000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
